// File: rtl/encoder_pkg.sv
// Shared constants for the active-low request encoder.
package encoder_pkg;

  // Decoding mode selectors
  localparam int MODE_STRICT = 0;
  localparam int MODE_PRIO   = 1;

  // Width of the saturating error counter
  localparam int ERR_CNT_W   = 16;

  // Saturating 2-bit increment used to classify "none / one / many" low bits
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    if (v == 2'd3) begin
      sat_inc2 = 2'd3;
    end else begin
      sat_inc2 = v + 2'd1;
    end
  endfunction

endpackage

// File: rtl/encoder_n_low_core.sv
// Combinational decoder for N active-low request lines.
// STRICT: exactly one low bit gives its index; anything else is an error.
// PRIO: the lowest-index low bit wins; no low bit is an error.
module encoder_n_low_core
  import encoder_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_STRICT,
  localparam int W   = $clog2(N)
) (
  input  logic [N-1:0] w,
  output logic [W-1:0] y,
  output logic         err
);

  logic [W-1:0] w_low_idx;
  logic [1:0]   w_low_cnt;

  // Scan from the top down so the last hit recorded is the lowest index
  always_comb begin
    w_low_idx = {W{1'b0}};
    w_low_cnt = 2'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!w[i]) begin
        w_low_idx = W'(i);
        w_low_cnt = sat_inc2(w_low_cnt);
      end else begin
        w_low_idx = w_low_idx;
      end
    end
  end

  // Map the scan result to code/error according to the selected mode
  always_comb begin
    y   = {W{1'b0}};
    err = 1'b1;
    if (MODE == MODE_PRIO) begin
      if (w_low_cnt != 2'd0) begin
        y   = w_low_idx;
        err = 1'b0;
      end else begin
        y   = {W{1'b0}};
        err = 1'b1;
      end
    end else begin
      if (w_low_cnt == 2'd1) begin
        y   = w_low_idx;
        err = 1'b0;
      end else begin
        y   = {W{1'b0}};
        err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_n_low_reg.sv
// Registered active-low encoder with a one-deep valid/ready result stage
// and a saturating count of accepted error results.
module encoder_n_low_reg
  import encoder_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_STRICT,
  localparam int W   = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         w,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         y,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic                 r_out_valid;
  logic [W-1:0]         r_y;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic [W-1:0]         w_core_y;
  logic                 w_core_err;
  logic                 w_accept;

  encoder_n_low_core #(
    .N    (N),
    .MODE (MODE)
  ) u_core (
    .w   (w),
    .y   (w_core_y),
    .err (w_core_err)
  );

  // The slot is free when empty or being drained this cycle
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Result register: load on accept, clear valid on drain, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= {W{1'b0}};
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_y         <= w_core_y;
      r_err       <= w_core_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Saturating count of accepted words that decode as errors
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= {ERR_CNT_W{1'b0}};
    end else if (w_accept && w_core_err && (r_err_count != {ERR_CNT_W{1'b1}})) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_encoder_n_low_reg.sv
// Directed bench: one STRICT and one PRIO instance (N=4) share all inputs.
module tb_encoder_n_low_reg;
  import encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  w;

  logic        s_in_ready, s_out_valid, s_err;
  logic [1:0]  s_y;
  logic [15:0] s_cnt;
  logic        p_in_ready, p_out_valid, p_err;
  logic [1:0]  p_y;
  logic [15:0] p_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder_n_low_reg #(.N(4), .MODE(MODE_STRICT)) u_strict (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .w(w),
    .out_valid(s_out_valid), .out_ready(out_ready), .y(s_y), .err(s_err),
    .err_count(s_cnt)
  );

  encoder_n_low_reg #(.N(4), .MODE(MODE_PRIO)) u_prio (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(p_in_ready), .w(w),
    .out_valid(p_out_valid), .out_ready(out_ready), .y(p_y), .err(p_err),
    .err_count(p_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] b2b_w [4];
    logic [3:0] bp_w [3];
    b2b_w[0] = 4'b1110; b2b_w[1] = 4'b1101; b2b_w[2] = 4'b1011; b2b_w[3] = 4'b0111;
    bp_w[0]  = 4'b1110; bp_w[1]  = 4'b1101; bp_w[2]  = 4'b0000;

    // Reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; w = 4'b1111;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_ov",    {31'd0, s_out_valid}, 32'd0);
    chk("rst_y",     {30'd0, s_y},         32'd0);
    chk("rst_err",   {31'd0, s_err},       32'd0);
    chk("rst_cnt",   {16'd0, s_cnt},       32'd0);
    chk("rst_rdy",   {31'd0, s_in_ready},  32'd1);

    // Single one-hot-low word
    w = 4'b1101; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("oh_ov",     {31'd0, s_out_valid}, 32'd1);
    chk("oh_y",      {30'd0, s_y},         32'd1);
    chk("oh_err",    {31'd0, s_err},       32'd0);
    chk("oh_cnt",    {16'd0, s_cnt},       32'd0);
    chk("oh_p_y",    {30'd0, p_y},         32'd1);

    // Two bits low: STRICT error, PRIO lowest index
    w = 4'b1001;
    tick();
    in_valid = 1'b0;
    chk("two_s_y",   {30'd0, s_y},         32'd0);
    chk("two_s_err", {31'd0, s_err},       32'd1);
    chk("two_s_cnt", {16'd0, s_cnt},       32'd1);
    chk("two_p_y",   {30'd0, p_y},         32'd1);
    chk("two_p_err", {31'd0, p_err},       32'd0);
    chk("two_p_cnt", {16'd0, p_cnt},       32'd0);

    // Drain with no new word
    tick();
    chk("drain_ov",  {31'd0, s_out_valid}, 32'd0);

    // Backpressure
    w = 4'b0111; in_valid = 1'b1;
    tick();
    chk("bp_y0",     {30'd0, s_y},         32'd3);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w = bp_w[k];
      #1;
      chk("bp_rdy",  {31'd0, s_in_ready},  32'd0);
      tick();
      chk("bp_ov",   {31'd0, s_out_valid}, 32'd1);
      chk("bp_y",    {30'd0, s_y},         32'd3);
      chk("bp_err",  {31'd0, s_err},       32'd0);
      chk("bp_cnt",  {16'd0, s_cnt},       32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_drain",  {31'd0, s_out_valid}, 32'd0);

    // Back-to-back accepts
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = b2b_w[k];
      tick();
      chk("b2b_ov",  {31'd0, s_out_valid}, 32'd1);
      chk("b2b_y",   {30'd0, s_y},         k);
      chk("b2b_p_y", {30'd0, p_y},         k);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_end",   {31'd0, s_out_valid}, 32'd0);

    // Reset while holding a result, with a word offered in the reset cycle
    w = 4'b1110; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("mr_pre_ov", {31'd0, s_out_valid}, 32'd1);
    out_ready = 1'b0; w = 4'b0000; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mr_ov",     {31'd0, s_out_valid}, 32'd0);
    chk("mr_y",      {30'd0, s_y},         32'd0);
    chk("mr_err",    {31'd0, s_err},       32'd0);
    chk("mr_cnt",    {16'd0, s_cnt},       32'd0);
    chk("mr_rdy",    {31'd0, s_in_ready},  32'd1);
    tick();
    chk("mr_noacc",  {31'd0, s_out_valid}, 32'd0);

    // All ones: error in both modes
    out_ready = 1'b1; in_valid = 1'b1; w = 4'b1111;
    tick();
    chk("ones_s_err",{31'd0, s_err},       32'd1);
    chk("ones_p_y",  {30'd0, p_y},         32'd0);
    chk("ones_p_err",{31'd0, p_err},       32'd1);
    chk("ones_p_cnt",{16'd0, p_cnt},       32'd1);

    // All zeros: STRICT error, PRIO index 0
    w = 4'b0000;
    tick();
    chk("zero_s_err",{31'd0, s_err},       32'd1);
    chk("zero_s_cnt",{16'd0, s_cnt},       32'd2);
    chk("zero_p_err",{31'd0, p_err},       32'd0);
    chk("zero_p_cnt",{16'd0, p_cnt},       32'd1);

    // Saturation: 65533 more errors brings STRICT to exactly FFFF
    w = 4'b1111;
    repeat (65533) @(posedge clk);
    #1;
    chk("sat_edge",  {16'd0, s_cnt},       32'h0000FFFF);
    repeat (4) @(posedge clk);
    in_valid = 1'b0;
    #1;
    chk("sat_s_cnt", {16'd0, s_cnt},       32'h0000FFFF);
    chk("sat_p_cnt", {16'd0, p_cnt},       32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_n_low_reg.md
ENCODER_N_LOW_REG -- requirements
Module: encoder_n_low_reg

Interface
REQ-001 The block SHALL have parameter N, default 8, number of active-low request lines (N >= 2).
REQ-002 The block SHALL have parameter MODE, default MODE_STRICT, selecting strict one-hot-low decoding (MODE_STRICT) or lowest-index priority decoding (MODE_PRIO).
REQ-003 The block SHALL have derived localparam W, value $clog2(N), output code width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  w carries a request word.
REQ-008 in_ready  output  1  block accepts w this cycle.
REQ-009 w  input  N  active-low request lines; bit i low = request i.
REQ-010 out_valid  output  1  y/err hold a result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 y  output  W  encoded index.
REQ-013 err  output  1  result flagged invalid.
REQ-014 err_count  output  ERR_CNT_W  saturating count of accepted error results.

Function
REQ-015 The block SHALL hold a single result register; in_ready = !out_valid || out_ready (combinational).
REQ-016 The block SHALL accept a word when in_valid && in_ready, and SHALL present its result with out_valid=1 on the next cycle (latency 1).
REQ-017 MODE_STRICT: exactly one bit of w low -> y = index of that bit, err=0; any other pattern (no bit low, or two or more low) -> y=0, err=1.
REQ-018 MODE_PRIO: y = lowest index i with w[i]=0, err=0; w all ones -> y=0, err=1.
REQ-019 While out_valid && !out_ready, y, err and out_valid SHALL remain stable.
REQ-020 out_valid SHALL clear on out_ready when no new word is accepted in the same cycle.
REQ-021 Simultaneous drain and accept (out_valid && out_ready && in_valid) SHALL replace the result with the new one, out_valid staying 1, no bubble.
REQ-022 err_count SHALL increment by 1 on each accepted word whose result has err=1, and SHALL saturate at all ones (no wrap).
REQ-023 Words presented while in_ready=0 SHALL be ignored, with no effect on err_count.

Reset
REQ-024 With rst=1 at a clock edge: out_valid=0, y=0, err=0, err_count=0; in_ready therefore reads 1 on the following cycle.
REQ-025 Reset mid-operation SHALL discard any pending result; a word presented in the reset cycle SHALL NOT be accepted.

Structure
REQ-026 Package encoder_pkg SHALL hold MODE_STRICT=0, MODE_PRIO=1, ERR_CNT_W=16.
REQ-027 Combinational decoding SHALL live in sub-module encoder_n_low_core (parameters N, MODE; ports w, y, err); encoder_n_low_reg SHALL add the handshake, result register and counter.

Verification
REQ-028 N=4 STRICT, w=4'b1101, in_valid=1, out_ready=1 -> next cycle out_valid=1, y=2'd1, err=0, err_count=0.
REQ-029 N=4 STRICT, w=4'b1001 -> y=0, err=1, err_count=1; same word with N=4 PRIO -> y=2'd1, err=0, err_count=0.
REQ-030 Backpressure: result for w=4'b0111 (y=3), out_ready=0 for 3 cycles while w changes -> y=3 stable, in_ready=0, no new accept; out_ready=1 -> drain.
REQ-031 Back-to-back: in_valid=1, out_ready=1 every cycle with w=1110,1101,1011,0111 -> y=0,1,2,3 on consecutive cycles, out_valid continuously 1.
REQ-032 Saturation: preload via 65537 accepted all-ones words -> err_count=16'hFFFF, not 0.
REQ-033 rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, y=0, err=0, err_count=0, in_ready=1.
